// File: rtl/fp_pkg.sv
// Shared binary32 definitions: field widths, constants, field-slice helpers
// and the accumulator state enum.
package fp_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    localparam logic [FP_W-1:0]  FP_ZERO = 32'h0000_0000;
    localparam logic [EXP_W-1:0] EXP_SAT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_e;

    // Sign bit of a binary32 word.
    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    // Biased exponent field of a binary32 word.
    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: EXP_W];
    endfunction

    // Mantissa field of a binary32 word.
    function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] x);
        return x[MAN_W-1:0];
    endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Operand stream, total stream, adder tap and status signals of fp_accumulator.
// slave = accumulator side, master = environment side.
interface fp_accumulator_if
    import fp_pkg::*;
#(
    parameter int unsigned CNT_W = 9
);

    logic             in_valid;
    logic             in_ready;
    logic [FP_W-1:0]  in_data;
    logic             in_last;

    logic [FP_W-1:0]  add_a;
    logic [FP_W-1:0]  add_b;
    logic [FP_W-1:0]  add_s;

    logic             out_valid;
    logic             out_ready;
    logic [FP_W-1:0]  out_data;
    logic [CNT_W-1:0] out_count;

    logic             busy;
    logic             ovf;

    modport slave (
        input  in_valid, in_data, in_last, out_ready, add_s,
        output in_ready, out_valid, out_data, out_count, add_a, add_b, busy, ovf
    );

    modport master (
        output in_valid, in_data, in_last, out_ready, add_s,
        input  in_ready, out_valid, out_data, out_count, add_a, add_b, busy, ovf
    );

endinterface

// File: rtl/fp_accumulator.sv
// Streaming binary32 frame accumulator wrapped around an external
// combinational fp_adder (a = running sum, b = incoming operand).
// Optional: define FP_ACC_OVF_EN to build the sticky exponent-saturation flag.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_accumulator_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

    acc_state_e       state_q, state_d;
    logic [FP_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FP_W-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    assign accept  = bus.in_valid & in_ready_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Frame sequencing: accumulate on accept, close on in_last or length limit.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE, ACC: begin
                // In IDLE acc/cnt are zero, so the same update starts a frame.
                if (accept) begin
                    acc_d   = bus.add_s;
                    cnt_d   = cnt_inc;
                    state_d = ACC;
                    if (bus.in_last || (cnt_inc == CNT_MAX)) begin
                        state_d     = HOLD;
                        out_data_d  = bus.add_s;
                        out_count_d = cnt_inc;
                        out_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = FP_ZERO;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d != HOLD);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= FP_ZERO;
            cnt_q       <= '0;
            out_data_q  <= FP_ZERO;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef FP_ACC_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky saturation flag, cleared by the total handshake of its frame.
    always_comb begin
        ovf_d = ovf_q;
        if (accept && (fp_exp(bus.add_s) == EXP_SAT)) begin
            ovf_d = 1'b1;
        end else if ((state_q == HOLD) && bus.out_ready) begin
            ovf_d = 1'b0;
        end
    end

    // Saturation flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.add_a     = acc_q;
    assign bus.add_b     = bus.in_data;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator: integer-valued binary32 operands,
// an arithmetic stand-in for fp_adder, and a frame-sum reference model.
module tb_fp_accumulator;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned CNT_W   = 9;

`ifdef FP_ACC_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    longint m_sum;
    int     m_cnt;

    fp_accumulator_if #(.CNT_W(CNT_W)) bus ();

    fp_accumulator #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // binary32 (integer-valued) -> integer
    function automatic longint f2i(input logic [31:0] f);
        int     e;
        longint m;
        if (f[30:23] == 8'h00) return 0;
        e = int'(f[30:23]) - 127;
        m = longint'({1'b1, f[22:0]});
        if (e >= 23)     m = m <<< (e - 23);
        else if (e >= 0) m = m >>> (23 - e);
        else             m = 0;
        return f[31] ? -m : m;
    endfunction

    // integer (|v| < 2^24) -> binary32, exact
    function automatic logic [31:0] i2f(input longint v);
        logic        s;
        logic [63:0] a;
        logic [63:0] mm;
        int          p;
        if (v == 0) return 32'h0000_0000;
        s = (v < 0);
        a = s ? 64'(-v) : 64'(v);
        p = 0;
        for (int i = 0; i < 63; i++) if (a[i]) p = i;
        if (p >= 23) mm = a >> (p - 23);
        else         mm = a << (23 - p);
        return {s, 8'(p + 127), mm[22:0]};
    endfunction

    // Stand-in for fp_adder on the value range this bench uses.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'h00) return b;
        if (b[30:23] == 8'h00) return a;
        if (a[30:23] >= 8'd167 || b[30:23] >= 8'd167) return 32'h7F80_0000;
        return i2f(f2i(a) + f2i(b));
    endfunction

    assign bus.add_s = ref_add(bus.add_a, bus.add_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_val();
        return i2f(longint'(int'($urandom_range(2000)) - 1000));
    endfunction

    // Present one operand (called just after a falling edge); returns at the
    // falling edge after the transfer and checks the frame result if it closed.
    task automatic send_op(input logic [31:0] d, input logic last, input bit track,
                           output bit closed);
        int waited;
        waited = 0;
        closed = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (track) begin
            m_sum += f2i(d);
            m_cnt++;
            if (last || m_cnt == int'(MAX_LEN)) begin
                closed = 1'b1;
                check("out_valid_latency", 32'(bus.out_valid), 32'd1);
                check("out_data", bus.out_data, i2f(m_sum));
                check("out_count", 32'(bus.out_count), 32'(m_cnt));
                check("in_ready_hold", 32'(bus.in_ready), 32'd0);
                check("busy_hold", 32'(bus.busy), 32'd1);
                m_sum = 0;
                m_cnt = 0;
            end else begin
                check("out_valid_open", 32'(bus.out_valid), 32'd0);
                check("busy_acc", 32'(bus.busy), 32'd1);
            end
        end
    endtask

    // Stall the total for 'stall' cycles (offering junk operands) then take it.
    task automatic drain(input int stall);
        logic [31:0] d0;
        logic [31:0] c0;
        d0 = bus.out_data;
        c0 = 32'(bus.out_count);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rand_val();
            bus.in_last  = 1'b1;
            @(negedge clk);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", bus.out_data, d0);
            check("stall_count", 32'(bus.out_count), c0);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        check("bubble_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_valid", 32'(bus.out_valid), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_busy", 32'(bus.busy), 32'd0);
        check("post_ovf", 32'(bus.ovf), 32'd0);
        check("acc_cleared", bus.add_a, 32'h0);
    endtask

    initial begin
        bit closed;
        int len;
        int gap;

        checks = 0;
        errors = 0;
        m_sum  = 0;
        m_cnt  = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_acc", bus.add_a, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Sequential sum 1+2+3
        send_op(32'h3F80_0000, 1'b0, 1'b1, closed);
        send_op(32'h4000_0000, 1'b0, 1'b1, closed);
        send_op(32'h4040_0000, 1'b1, 1'b1, closed);
        check("seq_sum_value", bus.out_data, 32'h40C0_0000);
        drain(0);

        // Single-operand frame
        send_op(32'hBF80_0000, 1'b1, 1'b1, closed);
        check("single_value", bus.out_data, 32'hBF80_0000);
        drain(1);

        // Cancellation to exact zero
        send_op(32'h3F80_0000, 1'b0, 1'b1, closed);
        send_op(32'hBF80_0000, 1'b1, 1'b1, closed);
        check("cancel_value", bus.out_data, 32'h0000_0000);
        drain(0);

        // Auto-close at MAX_LEN, then a fresh frame
        for (int i = 0; i < 4; i++) send_op(32'h3F80_0000, 1'b0, 1'b1, closed);
        check("autoclose_closed", 32'(closed), 32'd1);
        check("autoclose_value", bus.out_data, 32'h4080_0000);
        drain(0);
        send_op(32'h4000_0000, 1'b1, 1'b1, closed);
        check("new_frame_value", bus.out_data, 32'h4000_0000);

        // Backpressure: five stalled cycles
        drain(5);

        // Reset mid-frame discards partial sum
        send_op(32'h4000_0000, 1'b0, 1'b1, closed);
        send_op(32'h4040_0000, 1'b0, 1'b1, closed);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        m_sum = 0;
        m_cnt = 0;
        @(negedge clk);
        check("midrst_post_valid", 32'(bus.out_valid), 32'd0);
        send_op(32'h3F80_0000, 1'b1, 1'b1, closed);
        check("midrst_value", bus.out_data, 32'h3F80_0000);
        drain(2);

        // Randomised frames with idle gaps and random stalls
        for (int f = 0; f < 30; f++) begin
            len = int'($urandom_range(6, 1));
            for (int j = 0; j < len; j++) begin
                gap = int'($urandom_range(2));
                for (int g = 0; g < gap; g++) begin
                    bus.in_data = rand_val();
                    @(negedge clk);
                    check("gap_no_output", 32'(bus.out_valid), 32'd0);
                end
                send_op(rand_val(), 1'(j == len - 1), 1'b1, closed);
                if (closed) drain(int'($urandom_range(3)));
            end
        end

        // Exponent saturation
        send_op(32'h7F7F_FFFF, 1'b0, 1'b0, closed);
        check("ovf_first", 32'(bus.ovf), 32'd0);
        check("ovf_first_valid", 32'(bus.out_valid), 32'd0);
        send_op(32'h7F7F_FFFF, 1'b1, 1'b0, closed);
        check("ovf_valid", 32'(bus.out_valid), 32'd1);
        check("ovf_data", bus.out_data, 32'h7F80_0000);
        check("ovf_count", 32'(bus.out_count), 32'd2);
        check("ovf_flag", 32'(bus.ovf), 32'(OVF_EXP));
        drain(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
